fifo_uart_tx: RTL and testbench

Downstream drain stage for the 32-bit word FIFO. It pops one word at a time through the FIFO read port, which has one-cycle registered read latency. Each word is serialised as four UART 8N1 bytes, least-significant byte first, onto a single tx line. A status counter reports completed words for board-level debug.

---
 rtl/fifo_uart_tx.sv | 145 ++++++++++++++
 tb/tb_fifo_uart_tx.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// rtl/fifo_uart_tx.sv - FIFO drain stage serialising 32-bit words as four UART 8N1 bytes
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rd_empty,
  output logic             rd_en,
  input  logic [31:0]      rd_data,
  output logic             tx,
  output logic             busy,
  output logic [CNT_W-1:0] words_sent
);

  localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t            state, state_n;
  logic [BAUD_W-1:0] baud, baud_n;
  logic [2:0]        bit_idx, bit_idx_n, bit_next;
  logic [1:0]        byte_idx, byte_idx_n;
  logic [31:0]       shreg, shreg_n;
  logic [7:0]        cur_byte;
  logic              tx_n, rd_en_n;
  logic [CNT_W-1:0]  words_n;
  logic              baud_done;

  // The byte on the wire is always the low byte; the register shifts right between bytes.
  assign cur_byte  = shreg[7:0];
  assign bit_next  = bit_idx + 3'd1;
  assign baud_done = (baud == BAUD_LAST);
  assign busy      = (state != S_IDLE);

  // Next-state and next-output logic; tx and rd_en are computed one cycle ahead so both leave flops.
  always_comb begin
    state_n    = state;
    baud_n     = baud;
    bit_idx_n  = bit_idx;
    byte_idx_n = byte_idx;
    shreg_n    = shreg;
    tx_n       = tx;
    rd_en_n    = 1'b0;
    words_n    = words_sent;
    case (state)
      S_IDLE: begin
        tx_n = 1'b1;
        if (!rd_empty) begin
          state_n = S_REQ;
          rd_en_n = 1'b1;
        end
      end
      S_REQ: begin
        state_n = S_WAIT;
      end
      S_WAIT: begin
        shreg_n    = rd_data;
        byte_idx_n = 2'd0;
        baud_n     = '0;
        state_n    = S_START;
        tx_n       = 1'b0;
      end
      S_START: begin
        if (baud_done) begin
          baud_n    = '0;
          bit_idx_n = 3'd0;
          state_n   = S_DATA;
          tx_n      = cur_byte[0];
        end else begin
          baud_n = baud + BAUD_ONE;
        end
      end
      S_DATA: begin
        if (baud_done) begin
          baud_n = '0;
          if (bit_idx == 3'd7) begin
            state_n = S_STOP;
            tx_n    = 1'b1;
          end else begin
            bit_idx_n = bit_next;
            tx_n      = cur_byte[bit_next];
          end
        end else begin
          baud_n = baud + BAUD_ONE;
        end
      end
      S_STOP: begin
        if (baud_done) begin
          baud_n = '0;
          if (byte_idx != 2'd3) begin
            byte_idx_n = byte_idx + 2'd1;
            shreg_n    = {8'h00, shreg[31:8]};
            state_n    = S_START;
            tx_n       = 1'b0;
          end else begin
            words_n = words_sent + CNT_ONE;
            state_n = S_IDLE;
            tx_n    = 1'b1;
          end
        end else begin
          baud_n = baud + BAUD_ONE;
        end
      end
      default: begin
        state_n = S_IDLE;
        tx_n    = 1'b1;
      end
    endcase
  end

  // State and output registers; reset drops any in-flight word and forces the line idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      baud       <= '0;
      bit_idx    <= 3'd0;
      byte_idx   <= 2'd0;
      shreg      <= 32'd0;
      tx         <= 1'b1;
      rd_en      <= 1'b0;
      words_sent <= '0;
    end else begin
      state      <= state_n;
      baud       <= baud_n;
      bit_idx    <= bit_idx_n;
      byte_idx   <= byte_idx_n;
      shreg      <= shreg_n;
      tx         <= tx_n;
      rd_en      <= rd_en_n;
      words_sent <= words_n;
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb/tb_fifo_uart_tx.sv - self-checking bench for fifo_uart_tx
module tb_fifo_uart_tx;

  localparam int CPB   = 4;
  localparam int CNT_W = 2;
  localparam int FRAME = 40 * CPB;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             rd_empty = 1'b1;
  logic             rd_en;
  logic [31:0]      rd_data = 32'd0;
  logic             tx;
  logic             busy;
  logic [CNT_W-1:0] words_sent;

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .rd_empty   (rd_empty),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .tx         (tx),
    .busy       (busy),
    .words_sent (words_sent)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: FIFO contents plus the timeline of the word being sent.
  logic [31:0] q[$];
  int          cyc = 0;
  int          pop_cycle = -1;
  int          last_pop = -1000;
  logic        have = 1'b0;
  logic [31:0] cur_word = 32'd0;
  int          ws_exp = 0;
  logic        hold_empty = 1'b0;
  int          pops_seen = 0;
  int          last_rd_cyc = -1;

  typedef struct {
    int          n;
    logic [31:0] base;
    logic        randw;
    int          exp_pops;
    int          exp_ws;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  function automatic logic frame_bit(input logic [31:0] w, input int k);
    int b;
    int p;
    b = k / 10;
    p = k % 10;
    if (p == 0) return 1'b0;
    if (p == 9) return 1'b1;
    return w[b * 8 + p - 1];
  endfunction

  // One clock: compare at the falling edge, then drive inputs for the next rising edge.
  task automatic tick(input logic rst_next);
    logic e_rd;
    logic e_tx;
    int   k;
    @(negedge clk);
    cyc++;
    if (have && cyc == last_pop + 2 + FRAME) begin
      have   = 1'b0;
      ws_exp = (ws_exp + 1) % (1 << CNT_W);
    end
    e_rd = (pop_cycle == cyc);
    if (e_rd) begin
      have      = 1'b1;
      last_pop  = cyc;
      pop_cycle = -1;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL model_underflow cyc=%0d actual=empty expected=word", cyc);
        cur_word = 32'd0;
      end else begin
        cur_word = q.pop_front();
      end
    end
    e_tx = 1'b1;
    if (have && cyc >= last_pop + 2) begin
      k    = (cyc - last_pop - 2) / CPB;
      e_tx = frame_bit(cur_word, k);
    end
    if (rd_en === 1'b1) begin
      pops_seen++;
      last_rd_cyc = cyc;
    end
    chk("tx", 32'(tx), 32'(e_tx));
    chk("busy", 32'(busy), 32'(have));
    chk("rd_en", 32'(rd_en), 32'(e_rd));
    chk("words_sent", 32'(words_sent), 32'(ws_exp));
    if (have && cyc == last_pop) rd_data = cur_word;
    else if (!(have && cyc == last_pop + 1)) rd_data = $urandom;
    rst = rst_next;
    if (rst_next) begin
      have      = 1'b0;
      pop_cycle = -1;
      ws_exp    = 0;
      rd_empty  = 1'($urandom_range(0, 1));
    end else if (!have) begin
      rd_empty = (q.size() == 0) || hold_empty;
      if (!rd_empty) pop_cycle = cyc + 1;
    end else begin
      rd_empty = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic run_idle(input int budget);
    logic done;
    done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick(1'b0);
      if (q.size() == 0 && !have && pop_cycle < 0) begin
        done = 1'b1;
        break;
      end
    end
    chk("drain_done", 32'(done), 32'd1);
    for (int i = 0; i < 4; i++) tick(1'b0);
  endtask

  initial begin
    vec_t vecs[3];
    int   p0;
    int   rel_cyc;
    logic reached;

    vecs[0] = '{n: 1, base: 32'hA000_0003, randw: 1'b0, exp_pops: 1, exp_ws: 1};
    vecs[1] = '{n: 5, base: 32'hA000_0000, randw: 1'b0, exp_pops: 5, exp_ws: 2};
    vecs[2] = '{n: 3, base: 32'h0,         randw: 1'b1, exp_pops: 3, exp_ws: 1};

    // Reset held, then an empty FIFO must leave the line quiet.
    for (int i = 0; i < 5; i++) tick(1'b1);
    hold_empty = 1'b1;
    p0 = pops_seen;
    for (int i = 0; i < 200; i++) tick(1'b0);
    chk("idle_no_pop", 32'(pops_seen - p0), 32'd0);
    chk("idle_words", 32'(words_sent), 32'd0);
    hold_empty = 1'b0;

    // Word batches; counter width 2 exercises the wrap 2,3,0,1,2.
    for (int v = 0; v < 3; v++) begin
      for (int i = 0; i < vecs[v].n; i++)
        q.push_back(vecs[v].randw ? 32'($urandom) : vecs[v].base + 32'(i));
      p0 = pops_seen;
      run_idle(vecs[v].n * (FRAME + 10) + 50);
      chk("vec_pops", 32'(pops_seen - p0), 32'(vecs[v].exp_pops));
      chk("vec_words", 32'(words_sent), 32'(vecs[v].exp_ws));
    end

    // Reset in the middle of byte 1's data bits (byte 1 is zero, so tx is low there).
    q.push_back(32'h1234_0078);
    reached = 1'b0;
    for (int i = 0; i < 400; i++) begin
      tick(1'b0);
      if (have && cyc >= last_pop + 2 + 10 * CPB + 3 * CPB) begin
        reached = 1'b1;
        break;
      end
    end
    chk("reach_data_byte1", 32'(reached), 32'd1);
    chk("pre_rst_tx_low", 32'(tx), 32'd0);
    tick(1'b1);
    #1;
    chk("rst_async_tx", 32'(tx), 32'd1);
    chk("rst_async_busy", 32'(busy), 32'd0);
    chk("rst_async_rd_en", 32'(rd_en), 32'd0);
    chk("rst_async_words", 32'(words_sent), 32'd0);
    tick(1'b1);
    q.push_back(32'h5A5A_A5C3);
    p0 = pops_seen;
    tick(1'b0);
    rel_cyc = cyc;
    run_idle(FRAME + 50);
    chk("rst_repop_cycle", 32'(last_rd_cyc), 32'(rel_cyc + 1));
    chk("rst_repop_count", 32'(pops_seen - p0), 32'd1);
    chk("rst_words_after", 32'(words_sent), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
